// File: rtl/frame_arb_pkg.sv
// Shared state encoding and frame-length helper for frame_arbiter.
package frame_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  // Whole beats in a frame; partial trailing bytes are dropped, and an empty frame still carries one beat.
  function automatic logic [31:0] beats_of(input logic [31:0] frame_size, input int dw);
    logic [31:0] w_beats;
    w_beats = frame_size >> $clog2(dw / 8);
    return (w_beats == 32'd0) ? 32'd1 : w_beats;
  endfunction

endpackage

// File: rtl/frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping modulo NSRC.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int NSRC = 4,
  parameter int SW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [SW-1:0]   start,
  output logic            found,
  output logic [SW-1:0]   pick
);

  function automatic logic [SW-1:0] idx_of(input logic [SW-1:0] s, input int ofs);
    int t;
    t = int'(s) + ofs;
    if (t >= NSRC) t = t - NSRC;
    return SW'(t);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && req[idx_of(start, i)]) begin
        found = 1'b1;
        pick  = idx_of(start, i);
      end
    end
  end

endmodule

// File: rtl/frame_arbiter.sv
// Round-robin whole-frame arbiter: NSRC AXI-Stream sources onto one output; combinational datapath, one-cycle grant.
// Output backpressure passes straight to the granted source only. FRAME_ARB_B2B_EN removes the idle cycle between frames.
module frame_arbiter
  import frame_arb_pkg::*;
#(
  parameter int DW   = 512,
  parameter int NSRC = 4,
  parameter int SW   = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          frame_size,
  input  logic [NSRC-1:0]      src_enable,
  input  logic [NSRC*DW-1:0]   in_tdata,
  input  logic [NSRC-1:0]      in_tvalid,
  output logic [NSRC-1:0]      in_tready,
  output logic [DW-1:0]        out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_tlast,
  output logic [SW-1:0]        out_tuser,
  output logic                 busy,
  output logic [31:0]          frame_count
);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_grant, w_grant_nxt;
  logic [SW-1:0] r_last_grant, w_last_grant_nxt;
  logic [31:0]   r_beats, w_beats_nxt;
  logic [31:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [31:0]   r_frame_count, w_frame_count_nxt;

  logic [NSRC-1:0] w_req;
  logic [SW-1:0]   w_base;
  logic [SW-1:0]   w_start;
  logic [SW-1:0]   w_pick;
  logic            w_found;
  logic            w_hs;
  logic            w_last;

  assign w_req = src_enable & in_tvalid;

  // In PASS the search base is the current owner, which is only consulted for back-to-back regrant.
  assign w_base  = (r_state == PASS) ? r_grant : r_last_grant;
  assign w_start = (w_base == SW'(NSRC - 1)) ? '0 : w_base + SW'(1);

  rr_pick #(
    .NSRC (NSRC),
    .SW   (SW)
  ) u_rr_pick (
    .req   (w_req),
    .start (w_start),
    .found (w_found),
    .pick  (w_pick)
  );

  assign w_last = (r_beat_cnt == r_beats);
  assign w_hs   = (r_state == PASS) && in_tvalid[r_grant] && out_tready;

  always_comb begin
    out_tdata  = '0;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    out_tuser  = '0;
    in_tready  = '0;
    if (r_state == PASS) begin
      out_tdata          = in_tdata[int'(r_grant) * DW +: DW];
      out_tvalid         = in_tvalid[r_grant];
      out_tlast          = w_last;
      out_tuser          = r_grant;
      in_tready[r_grant] = out_tready;
    end
  end

  assign busy        = (r_state == PASS);
  assign frame_count = r_frame_count;

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_last_grant_nxt  = r_last_grant;
    w_beats_nxt       = r_beats;
    w_beat_cnt_nxt    = r_beat_cnt;
    w_frame_count_nxt = r_frame_count;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = PASS;
          w_grant_nxt    = w_pick;
          w_beats_nxt    = beats_of(frame_size, DW);
          w_beat_cnt_nxt = 32'd1;
        end
      end
      PASS: begin
        if (w_hs) begin
          if (!w_last) begin
            w_beat_cnt_nxt = r_beat_cnt + 32'd1;
          end else begin
            w_frame_count_nxt = r_frame_count + 32'd1;
            w_last_grant_nxt  = r_grant;
            w_state_nxt       = IDLE;
`ifdef FRAME_ARB_B2B_EN
            if (w_found) begin
              w_state_nxt    = PASS;
              w_grant_nxt    = w_pick;
              w_beats_nxt    = beats_of(frame_size, DW);
              w_beat_cnt_nxt = 32'd1;
            end
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_last_grant  <= SW'(NSRC - 1);
      r_beats       <= 32'd1;
      r_beat_cnt    <= 32'd1;
      r_frame_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_beats       <= w_beats_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

endmodule
